// File: rtl/cfg_lut_pkg.sv
// Shared types and helpers for the configurable look-up table.
package cfg_lut_pkg;

   typedef enum logic [1:0] {
      UNCONF = 2'd0,
      LOAD   = 2'd1,
      READY  = 2'd2
   } cfg_state_e;

   // One mode bit followed by a 2**k-entry truth table.
   function automatic int unsigned cfg_width(input int unsigned k);
      return (32'd1 << k) + 32'd1;
   endfunction

endpackage

// File: rtl/lut_mux.sv
// Purely combinational 2**K:1 truth-table select.
module lut_mux #(
   parameter int unsigned K = 4
) (
   input  logic [(2**K)-1:0] tbl,
   input  logic [K-1:0]      sel,
   output logic              f
);

   assign f = tbl[sel];

endmodule

// File: rtl/cfg_lut.sv
// Serially configured K-input LUT with optional registered output and daisy-chained config.
module cfg_lut
   import cfg_lut_pkg::*;
#(
   parameter int unsigned K = 4  // legal range 2..6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         lut_en,
   input  logic [K-1:0] lut_sel,
   input  logic         cfg_en,
   input  logic         cfg_in,
   output logic         cfg_out,
   output logic         cfg_done,
   output logic         cfg_err,
   output logic         lut_out
);

   localparam int unsigned TW    = 2 ** K;
   localparam int unsigned CFG_W = cfg_width(K);
   localparam int unsigned CNT_W = $clog2(CFG_W + 1);

   cfg_state_e       state_q, state_d;
   logic [CFG_W-1:0] cfg_reg_q, cfg_reg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             err_q, err_d;
   logic             mode;
   logic             f;

   assign mode = cfg_reg_q[CFG_W-1];

   lut_mux #(
      .K(K)
   ) u_lut_mux (
      .tbl(cfg_reg_q[TW-1:0]),
      .sel(lut_sel),
      .f  (f)
   );

   always_comb begin
      state_d   = state_q;
      cfg_reg_d = cfg_reg_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      err_d     = err_q;
      if (cfg_en) begin
         // Every enabled cycle shifts, including the one that enters LOAD.
         state_d   = LOAD;
         cfg_reg_d = {cfg_reg_q[CFG_W-2:0], cfg_in};
         q_d       = 1'b0;
         err_d     = 1'b0;
         if (state_q != LOAD) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != CNT_W'(CFG_W)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         unique case (state_q)
            LOAD: begin
               if (cnt_q == CNT_W'(CFG_W)) begin
                  state_d = READY;
               end else begin
                  state_d = UNCONF;
                  err_d   = 1'b1;
               end
            end
            READY: begin
               if (mode && lut_en) begin
                  q_d = f;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNCONF;
         cfg_reg_q <= '0;
         cnt_q     <= '0;
         q_q       <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_reg_q <= cfg_reg_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         err_q     <= err_d;
      end
   end

   assign cfg_out  = cfg_reg_q[CFG_W-1];
   assign cfg_done = (state_q == READY);
   assign cfg_err  = err_q;
   assign lut_out  = (state_q == READY) && lut_en && (mode ? q_q : f);

endmodule

// File: tb/tb_cfg_lut.sv
// Directed self-checking bench for cfg_lut with K=4 (17-bit configuration frame).
module tb_cfg_lut;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lut_en;
   logic [3:0] lut_sel;
   logic       cfg_en;
   logic       cfg_in;
   logic       cfg_out;
   logic       cfg_done;
   logic       cfg_err;
   logic       lut_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cfg_lut #(
      .K(4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .lut_en  (lut_en),
      .lut_sel (lut_sel),
      .cfg_en  (cfg_en),
      .cfg_in  (cfg_in),
      .cfg_out (cfg_out),
      .cfg_done(cfg_done),
      .cfg_err (cfg_err),
      .lut_out (lut_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Shifts the low n bits of bits, most significant first, then drops cfg_en.
   task automatic shift_bits(input logic [33:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         cfg_en = 1'b1;
         cfg_in = bits[i];
         step();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   task automatic load_frame(input logic [16:0] fr);
      shift_bits({17'b0, fr}, 17);
      step();
   endtask

   task automatic test_reset();
      rst_n   = 1'b1;
      lut_en  = 1'b1;
      lut_sel = 4'd0;
      cfg_en  = 1'b0;
      cfg_in  = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (cfg_out !== 1'b0) begin errors++; $display("FAIL reset_cfg_out got=%b exp=0", cfg_out); end
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done got=%b exp=0", cfg_done); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL reset_lut_out got=%b exp=0", lut_out); end
      step();
      rst_n = 1'b1;
      step();
      // Configure, then hit reset mid-cycle with no clock edge.
      load_frame({1'b1, 16'hA5C3});
      checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL pre_reset_done got=%b exp=1", cfg_done); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL async_reset_done got=%b exp=0", cfg_done); end
      checks++; if (cfg_out !== 1'b0) begin errors++; $display("FAIL async_reset_cfg_out got=%b exp=0", cfg_out); end
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL async_reset_lut_out got=%b exp=0", lut_out); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL post_reset_unconf got=%b exp=0", cfg_done); end
   endtask

   task automatic test_comb_mode();
      logic [3:0] sels [6] = '{4'd0, 4'd2, 4'd15, 4'd6, 4'd9, 4'd10};
      logic       exps [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      lut_en = 1'b1;
      shift_bits({17'b0, 1'b0, 16'hA5C3}, 17);
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL comb_done_early got=%b exp=0", cfg_done); end
      step();
      checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL comb_done got=%b exp=1", cfg_done); end
      checks++; if (cfg_out !== 1'b0) begin errors++; $display("FAIL comb_cfg_out got=%b exp=0", cfg_out); end
      for (int i = 0; i < 6; i++) begin
         lut_sel = sels[i];
         #1;
         checks++;
         if (lut_out !== exps[i]) begin
            errors++;
            $display("FAIL comb_sel%0d got=%b exp=%b", sels[i], lut_out, exps[i]);
         end
      end
      lut_en = 1'b0;
      #1;
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL comb_lut_en_off got=%b exp=0", lut_out); end
   endtask

   task automatic test_reg_mode();
      lut_en  = 1'b1;
      lut_sel = 4'd0;
      load_frame({1'b1, 16'hA5C3});
      checks++; if (cfg_out !== 1'b1) begin errors++; $display("FAIL reg_cfg_out got=%b exp=1", cfg_out); end
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL reg_q_cleared got=%b exp=0", lut_out); end
      step();
      checks++; if (lut_out !== 1'b1) begin errors++; $display("FAIL reg_sel0 got=%b exp=1", lut_out); end
      lut_sel = 4'd2;
      #1;
      checks++; if (lut_out !== 1'b1) begin errors++; $display("FAIL reg_latency got=%b exp=1", lut_out); end
      step();
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL reg_sel2 got=%b exp=0", lut_out); end
      lut_sel = 4'd0;
      lut_en  = 1'b0;
      #1;
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL reg_en_off got=%b exp=0", lut_out); end
      step();
      lut_en = 1'b1;
      #1;
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL reg_q_held got=%b exp=0", lut_out); end
      step();
      checks++; if (lut_out !== 1'b1) begin errors++; $display("FAIL reg_reload got=%b exp=1", lut_out); end
   endtask

   task automatic test_cfg_rise_and_short_load();
      logic [16:0] fr;
      cfg_en = 1'b1;
      cfg_in = 1'b0;
      #1;
      checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL rise_done_before got=%b exp=1", cfg_done); end
      checks++; if (lut_out !== 1'b1) begin errors++; $display("FAIL rise_out_before got=%b exp=1", lut_out); end
      step();
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rise_done_after got=%b exp=0", cfg_done); end
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL rise_out_after got=%b exp=0", lut_out); end
      // Nine more bits make a ten-bit short load.
      shift_bits(34'h1AB, 9);
      step();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL short_err got=%b exp=1", cfg_err); end
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL short_done got=%b exp=0", cfg_done); end
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL short_lut_out got=%b exp=0", lut_out); end
      step();
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL short_err_sticky got=%b exp=1", cfg_err); end
      fr = {1'b0, 16'h0F0F};
      shift_bits({33'b0, fr[16]}, 1);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear_entry got=%b exp=0", cfg_err); end
      shift_bits({18'b0, fr[15:0]}, 16);
      step();
      checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL reload_done got=%b exp=1", cfg_done); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reload_err got=%b exp=0", cfg_err); end
   endtask

   task automatic test_daisy();
      logic [33:0] stream;
      logic [15:0] b_tbl;
      stream = {1'b1, 16'h1234, 1'b0, 16'h6C39};
      b_tbl  = 16'h6C39;
      for (int n = 1; n <= 34; n++) begin
         cfg_en = 1'b1;
         cfg_in = stream[34-n];
         step();
         if (n >= 17) begin
            checks++;
            if (cfg_out !== stream[50-n]) begin
               errors++;
               $display("FAIL daisy_edge%0d got=%b exp=%b", n, cfg_out, stream[50-n]);
            end
         end
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      step();
      checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL daisy_done got=%b exp=1", cfg_done); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL daisy_err got=%b exp=0", cfg_err); end
      lut_en = 1'b1;
      for (int s = 0; s < 16; s++) begin
         lut_sel = 4'(s);
         #1;
         checks++;
         if (lut_out !== b_tbl[s]) begin
            errors++;
            $display("FAIL daisy_frame_b_sel%0d got=%b exp=%b", s, lut_out, b_tbl[s]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [15:0] d_tbl;
      d_tbl = 16'h3C96;
      shift_bits(34'hFF, 8);
      rst_n = 1'b0;
      #2;
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL midload_reset_done got=%b exp=0", cfg_done); end
      checks++; if (cfg_out !== 1'b0) begin errors++; $display("FAIL midload_reset_cfg_out got=%b exp=0", cfg_out); end
      step();
      rst_n = 1'b1;
      step();
      step();
      lut_en = 1'b1;
      #1;
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL midload_needs_reload got=%b exp=0", cfg_done); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL midload_err got=%b exp=0", cfg_err); end
      checks++; if (lut_out !== 1'b0) begin errors++; $display("FAIL midload_lut_out got=%b exp=0", lut_out); end
      load_frame({1'b0, d_tbl});
      checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL midload_reload_done got=%b exp=1", cfg_done); end
      for (int s = 0; s < 16; s++) begin
         lut_sel = 4'(s);
         #1;
         checks++;
         if (lut_out !== d_tbl[s]) begin
            errors++;
            $display("FAIL midload_sel%0d got=%b exp=%b", s, lut_out, d_tbl[s]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_comb_mode();
      test_reg_mode();
      test_cfg_rise_and_short_load();
      test_daisy();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
